// File: rtl/wb_pkg.sv
// Shared types and default widths for the register-file writeback path.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_MC
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Drives the register file write port from the pipeline WB stage (priority) and the
// long-latency result FIFO, and tracks destinations with results still outstanding.
module wb_write_arbiter #(
  parameter int XLEN     = wb_pkg::XLEN,
  parameter int REG_AW   = wb_pkg::REG_AW,
  parameter int LQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pipe_we,
  input  logic [REG_AW-1:0]    pipe_rd,
  input  logic [XLEN-1:0]      pipe_wd,
  input  logic                 mc_valid,
  output logic                 mc_ready,
  input  logic [REG_AW-1:0]    mc_rd,
  input  logic [XLEN-1:0]      mc_wd,
  input  logic                 issue_valid,
  input  logic [REG_AW-1:0]    issue_rd,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_rd,
  output logic [XLEN-1:0]      rf_wd,
  output logic [2**REG_AW-1:0] pend_mask,
  output logic                 issue_err
);

  import wb_pkg::*;

  localparam int NREG = 2**REG_AW;
  localparam int CW   = $clog2(LQ_DEPTH) + 1;
  localparam int QW   = REG_AW + XLEN;

  logic [QW-1:0]     head;
  logic [REG_AW-1:0] head_rd;
  logic [XLEN-1:0]   head_wd;
  logic              lq_full;
  logic              lq_empty;
  logic [CW-1:0]     lq_count;
  logic              lq_push;
  logic              lq_pop;
  wb_src_e           src;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic              dup_issue;

  // Results for x0 are accepted on the handshake but never stored.
  assign mc_ready = (lq_count != CW'(LQ_DEPTH));
  assign lq_push  = mc_valid && !lq_full && (mc_rd != '0);
  assign lq_pop   = (src == SRC_MC);
  assign head_rd  = head[QW-1:XLEN];
  assign head_wd  = head[XLEN-1:0];

  wb_fifo #(
    .W     (QW),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (lq_push),
    .din   ({mc_rd, mc_wd}),
    .pop   (lq_pop),
    .dout  (head),
    .full  (lq_full),
    .empty (lq_empty),
    .count (lq_count)
  );

  always_comb begin
    src = SRC_NONE;
    if (pipe_we && (pipe_rd != '0)) src = SRC_PIPE;
    else if (!lq_empty)             src = SRC_MC;
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && (issue_rd != '0)) set_vec[issue_rd] = 1'b1;
    if (lq_pop)                          clr_vec[head_rd]  = 1'b1;
  end

  // A duplicate issue is only an error if the same edge is not retiring that rd.
  assign dup_issue = |(set_vec & pend_mask & ~clr_vec);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we     <= 1'b0;
      rf_rd     <= '0;
      rf_wd     <= '0;
      pend_mask <= '0;
      issue_err <= 1'b0;
    end else begin
      case (src)
        SRC_PIPE: begin
          rf_we <= 1'b1;
          rf_rd <= pipe_rd;
          rf_wd <= pipe_wd;
        end
        SRC_MC: begin
          rf_we <= 1'b1;
          rf_rd <= head_rd;
          rf_wd <= head_wd;
        end
        default: rf_we <= 1'b0;
      endcase
      pend_mask <= ((pend_mask & ~clr_vec) | set_vec) & ~NREG'(1);
      if (dup_issue) issue_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and randomized checks of wb_write_arbiter against a queue-based reference model.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_rd;
  logic [31:0] mc_wd;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] pend_mask;
  logic        issue_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [36:0] q_m[$];
  logic [31:0] pend_m;
  logic        err_m;
  logic        we_m;
  logic [4:0]  rd_m;
  logic [31:0] wd_m;
  logic        hold_v = 1'b0;
  logic [4:0]  hold_rd;
  logic [31:0] hold_wd;
  logic        inited = 1'b0;

  wb_write_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pipe_we     (pipe_we),
    .pipe_rd     (pipe_rd),
    .pipe_wd     (pipe_wd),
    .mc_valid    (mc_valid),
    .mc_ready    (mc_ready),
    .mc_rd       (mc_rd),
    .mc_wd       (mc_wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wd       (rf_wd),
    .pend_mask   (pend_mask),
    .issue_err   (issue_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model by the behavioural rules, compare after the edge.
  task automatic step(input logic rst, input logic pwe, input logic [4:0] prd,
                      input logic [31:0] pwd, input logic mv, input logic [4:0] mrd,
                      input logic [31:0] mwd, input logic iv, input logic [4:0] ird);
    logic        exp_ready;
    logic        popped;
    logic [4:0]  pop_rd;
    logic [31:0] pend_before;
    if (hold_v && rst) begin
      mv  = 1'b1;
      mrd = hold_rd;
      mwd = hold_wd;
    end
    rst_n = rst; pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
    mc_valid = mv; mc_rd = mrd; mc_wd = mwd; issue_valid = iv; issue_rd = ird;
    exp_ready = (q_m.size() != 4);
    if (inited) chk("mc_ready", {31'd0, mc_ready}, {31'd0, exp_ready});
    if (!rst) begin
      q_m.delete();
      pend_m = '0; err_m = 1'b0; we_m = 1'b0; rd_m = '0; wd_m = '0;
      hold_v = 1'b0;
      inited = 1'b1;
    end else begin
      popped = 1'b0;
      pop_rd = '0;
      pend_before = pend_m;
      we_m = 1'b0;
      if (pwe && prd != 0) begin
        we_m = 1'b1; rd_m = prd; wd_m = pwd;
      end else if (q_m.size() > 0) begin
        {pop_rd, wd_m} = q_m.pop_front();
        rd_m = pop_rd; we_m = 1'b1; popped = 1'b1;
        pend_m[pop_rd] = 1'b0;
      end
      if (mv && exp_ready && mrd != 0) q_m.push_back({mrd, mwd});
      hold_v = mv && !exp_ready;
      hold_rd = mrd;
      hold_wd = mwd;
      if (iv && ird != 0) begin
        if (pend_before[ird] && !(popped && pop_rd == ird)) err_m = 1'b1;
        pend_m[ird] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, we_m});
    chk("rf_rd", {27'd0, rf_rd}, {27'd0, rd_m});
    chk("rf_wd", rf_wd, wd_m);
    chk("pend_mask", pend_mask, pend_m);
    chk("issue_err", {31'd0, issue_err}, {31'd0, err_m});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset while traffic is present
    for (int i = 0; i < 3; i++) step(0, 1, 5'd4, 32'h55, 1, 5'd6, 32'h66, 1, 5'd8);
    chk("reset_ready", {31'd0, mc_ready}, 32'd1);
    idle(1);

    // Lone long-latency result
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd5);
    chk("lone_pend_set", {31'd0, pend_mask[5]}, 32'd1);
    step(1, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lone_wd", rf_wd, 32'hDEADBEEF);
    chk("lone_pend_clr", {31'd0, pend_mask[5]}, 32'd0);
    idle(1);

    // Pipeline priority over a queued result
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    step(1, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 5'd3, 32'h11, 0, 0, 0, 0, 0);
    chk("prio_pend7", {31'd0, pend_mask[7]}, 32'd1);
    idle(2);

    // Fill the FIFO behind a busy pipeline; the fifth result waits
    for (int i = 0; i < 5; i++)
      step(1, 1, 5'd3, 32'h100 + i, 1, 5'(10 + i), 32'hA0 + i, 0, 0);
    chk("full_ready", {31'd0, mc_ready}, 32'd0);
    idle(7);

    // x0 writes from both sides, and the FIFO draining behind a pipe x0 write
    step(1, 1, 5'd0, 32'h77, 1, 5'd0, 32'h88, 0, 0);
    step(1, 1, 5'd3, 32'h33, 1, 5'd12, 32'hC0, 0, 0);
    step(1, 1, 5'd0, 32'h99, 0, 0, 0, 0, 0);
    idle(1);

    // Scoreboard: duplicate issue, then issue coinciding with the retiring pop
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    chk("dup_err", {31'd0, issue_err}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    step(1, 0, 0, 0, 1, 5'd9, 32'h9999, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    chk("same_edge_pend9", {31'd0, pend_mask[9]}, 32'd1);
    chk("same_edge_err", {31'd0, issue_err}, 32'd0);
    idle(1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
